// File: rtl/uart_lite_responder.sv
// uart_lite_responder: AXI4-Lite slave with the UART-Lite register map, backed by RX/TX byte FIFOs.
// Revision 1.0 - initial release.
`default_nettype none

module uart_lite_fifo #(
  parameter int DEPTH = 16,
  parameter int BITS  = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            flush_i,
  input  logic            push_i,
  input  logic [7:0]      din_i,
  input  logic            pop_i,
  output logic [7:0]      head_o,
  output logic [BITS:0]   count_o,
  output logic            full_o,
  output logic            empty_o
);
  localparam logic [BITS-1:0] PTR_ONE   = {{(BITS-1){1'b0}}, 1'b1};
  localparam logic [BITS:0]   CNT_ONE   = {{BITS{1'b0}}, 1'b1};
  localparam logic [BITS:0]   CNT_DEPTH = (BITS+1)'(DEPTH);

  logic [7:0]      mem_q [DEPTH];
  logic [BITS-1:0] wr_ptr_q, rd_ptr_q;
  logic [BITS:0]   count_q;
  logic            do_push, do_pop;

  assign full_o  = (count_q == CNT_DEPTH);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = empty_o ? 8'h00 : mem_q[rd_ptr_q];

  // A push into a full FIFO is refused even when a pop frees a slot this cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (!rstn || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end
endmodule

module uart_lite_responder #(
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_BITS  = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [3:0]  s_axi_awaddr,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [3:0]  s_axi_araddr,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  input  logic [7:0]  rx_in_data,
  input  logic        rx_in_vld,
  input  logic        rx_in_frame,
  input  logic        rx_in_par,
  output logic [7:0]  tx_out_data,
  output logic        tx_out_vld,
  input  logic        tx_out_rdy,
  output logic        interrupt
);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [0:0] {W_IDLE = 1'b0, W_RESP = 1'b1} wstate_t;
  typedef enum logic [0:0] {R_IDLE = 1'b0, R_RESP = 1'b1} rstate_t;

  wstate_t     wstate_q, wstate_d;
  rstate_t     rstate_q, rstate_d;
  logic        awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
  logic        aw_got_q, aw_got_d, w_got_q, w_got_d;
  logic [1:0]  awsel_q, awsel_d;
  logic [7:0]  wbyte_q, wbyte_d;
  logic        wstrb0_q, wstrb0_d;
  logic        bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        intr_en_q, intr_en_d;
  logic        par_q, par_d, frame_q, frame_d, ovr_q, ovr_d;
  logic        rx_valid_prev_q, tx_empty_prev_q, intr_q;

  logic        aw_fire, w_fire, ar_fire;
  logic [1:0]  wr_sel;
  logic [7:0]  wr_byte;
  logic        wr_strb0;
  logic        tx_push, tx_flush, rx_flush, rx_pop, stat_clr, rx_accept;
  logic [7:0]  rx_head, tx_head, stat;
  logic [FIFO_BITS:0] rx_count, tx_count;
  logic        rx_full, rx_empty, tx_full, tx_empty, rx_valid;
  logic        unused_bits;

  assign unused_bits = ^{s_axi_awaddr[1:0], s_axi_wdata[31:8], s_axi_wstrb[3:1],
                         s_axi_araddr[1:0], rx_count, tx_count};

  uart_lite_fifo #(.DEPTH(FIFO_DEPTH), .BITS(FIFO_BITS)) u_rx_fifo (
    .clk(clk), .rstn(rstn), .flush_i(rx_flush), .push_i(rx_in_vld), .din_i(rx_in_data),
    .pop_i(rx_pop), .head_o(rx_head), .count_o(rx_count), .full_o(rx_full), .empty_o(rx_empty)
  );

  uart_lite_fifo #(.DEPTH(FIFO_DEPTH), .BITS(FIFO_BITS)) u_tx_fifo (
    .clk(clk), .rstn(rstn), .flush_i(tx_flush), .push_i(tx_push), .din_i(wr_byte),
    .pop_i(tx_out_vld && tx_out_rdy), .head_o(tx_head), .count_o(tx_count),
    .full_o(tx_full), .empty_o(tx_empty)
  );

  assign rx_valid  = !rx_empty;
  assign stat      = {par_q, frame_q, ovr_q, intr_en_q, tx_full, tx_empty, rx_full, rx_valid};
  assign aw_fire   = s_axi_awready && s_axi_awvalid;
  assign w_fire    = s_axi_wready && s_axi_wvalid;
  assign ar_fire   = s_axi_arready && s_axi_arvalid;
  assign rx_accept = rx_in_vld && !rx_full;

  // A beat latched earlier takes precedence over the bus, which may already carry the next one.
  assign wr_sel   = aw_got_q ? awsel_q  : s_axi_awaddr[3:2];
  assign wr_byte  = w_got_q  ? wbyte_q  : s_axi_wdata[7:0];
  assign wr_strb0 = w_got_q  ? wstrb0_q : s_axi_wstrb[0];

  always_comb begin
    wstate_d  = wstate_q;
    aw_got_d  = aw_got_q;
    w_got_d   = w_got_q;
    awsel_d   = awsel_q;
    wbyte_d   = wbyte_q;
    wstrb0_d  = wstrb0_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    intr_en_d = intr_en_q;
    tx_push   = 1'b0;
    tx_flush  = 1'b0;
    rx_flush  = 1'b0;
    case (wstate_q)
      W_IDLE: begin
        if (aw_fire) begin
          aw_got_d = 1'b1;
          awsel_d  = s_axi_awaddr[3:2];
        end
        if (w_fire) begin
          w_got_d  = 1'b1;
          wbyte_d  = s_axi_wdata[7:0];
          wstrb0_d = s_axi_wstrb[0];
        end
        if ((aw_got_q || aw_fire) && (w_got_q || w_fire)) begin
          aw_got_d  = 1'b0;
          w_got_d   = 1'b0;
          bvalid_d  = 1'b1;
          bresp_d   = RESP_OKAY;
          wstate_d  = W_RESP;
          case (wr_sel)
            2'b01: begin
              if (tx_full) bresp_d = RESP_SLVERR;
              else         tx_push = wr_strb0;
            end
            2'b11: begin
              if (wr_strb0) begin
                tx_flush  = wr_byte[0];
                rx_flush  = wr_byte[1];
                intr_en_d = wr_byte[4];
              end
            end
            default: bresp_d = RESP_SLVERR;
          endcase
        end
      end
      W_RESP: begin
        if (s_axi_bready) begin
          bvalid_d = 1'b0;
          wstate_d = W_IDLE;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
    awready_d = (wstate_d == W_IDLE) && !aw_got_d;
    wready_d  = (wstate_d == W_IDLE) && !w_got_d;
  end

  always_comb begin
    rstate_d = rstate_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rx_pop   = 1'b0;
    stat_clr = 1'b0;
    case (rstate_q)
      R_IDLE: begin
        if (ar_fire) begin
          rvalid_d = 1'b1;
          rstate_d = R_RESP;
          case (s_axi_araddr[3:2])
            2'b00: begin
              rdata_d = rx_head;
              rx_pop  = !rx_empty;
            end
            2'b10: begin
              rdata_d  = stat;
              stat_clr = 1'b1;
            end
            default: rdata_d = 8'h00;
          endcase
        end
      end
      R_RESP: begin
        if (s_axi_rready) begin
          rvalid_d = 1'b0;
          rstate_d = R_IDLE;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
    arready_d = (rstate_d == R_IDLE);
  end

  // New errors are OR-ed in after the clear so a same-cycle error survives a STAT read.
  always_comb begin
    par_d   = (stat_clr ? 1'b0 : par_q)   | (rx_accept && rx_in_par);
    frame_d = (stat_clr ? 1'b0 : frame_q) | (rx_accept && rx_in_frame);
    ovr_d   = (stat_clr ? 1'b0 : ovr_q)   | (rx_in_vld && rx_full);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wstate_q        <= W_IDLE;
      rstate_q        <= R_IDLE;
      awready_q       <= 1'b0;
      wready_q        <= 1'b0;
      arready_q       <= 1'b0;
      aw_got_q        <= 1'b0;
      w_got_q         <= 1'b0;
      awsel_q         <= 2'b00;
      wbyte_q         <= 8'h00;
      wstrb0_q        <= 1'b0;
      bvalid_q        <= 1'b0;
      bresp_q         <= RESP_OKAY;
      rvalid_q        <= 1'b0;
      rdata_q         <= 8'h00;
      intr_en_q       <= 1'b0;
      par_q           <= 1'b0;
      frame_q         <= 1'b0;
      ovr_q           <= 1'b0;
      rx_valid_prev_q <= 1'b0;
      tx_empty_prev_q <= 1'b1;
      intr_q          <= 1'b0;
    end else begin
      wstate_q        <= wstate_d;
      rstate_q        <= rstate_d;
      awready_q       <= awready_d;
      wready_q        <= wready_d;
      arready_q       <= arready_d;
      aw_got_q        <= aw_got_d;
      w_got_q         <= w_got_d;
      awsel_q         <= awsel_d;
      wbyte_q         <= wbyte_d;
      wstrb0_q        <= wstrb0_d;
      bvalid_q        <= bvalid_d;
      bresp_q         <= bresp_d;
      rvalid_q        <= rvalid_d;
      rdata_q         <= rdata_d;
      intr_en_q       <= intr_en_d;
      par_q           <= par_d;
      frame_q         <= frame_d;
      ovr_q           <= ovr_d;
      rx_valid_prev_q <= rx_valid;
      tx_empty_prev_q <= tx_empty;
      intr_q          <= intr_en_q && ((rx_valid && !rx_valid_prev_q) ||
                                       (tx_empty && !tx_empty_prev_q));
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_arready = arready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = {24'h000000, rdata_q};
  assign s_axi_rresp   = RESP_OKAY;
  assign tx_out_data   = tx_head;
  assign tx_out_vld    = !tx_empty;
  assign interrupt     = intr_q;
endmodule

`default_nettype wire

// File: tb/tb_uart_lite_responder.sv
// tb_uart_lite_responder: directed self-checking bench for uart_lite_responder.
// Revision 1.0 - initial release.
`default_nettype none

module tb_uart_lite_responder;
  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  s_axi_awaddr;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic [3:0]  s_axi_araddr;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready;
  logic [7:0]  rx_in_data;
  logic        rx_in_vld;
  logic        rx_in_frame;
  logic        rx_in_par;
  logic [7:0]  tx_out_data;
  logic        tx_out_vld;
  logic        tx_out_rdy;
  logic        interrupt;

  int n_tests = 0;
  int n_fail  = 0;

  uart_lite_responder #(.FIFO_DEPTH(16), .FIFO_BITS(4)) dut (
    .clk(clk), .rstn(rstn),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .rx_in_data(rx_in_data),
    .rx_in_vld(rx_in_vld), .rx_in_frame(rx_in_frame), .rx_in_par(rx_in_par),
    .tx_out_data(tx_out_data), .tx_out_vld(tx_out_vld), .tx_out_rdy(tx_out_rdy),
    .interrupt(interrupt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
    int n;
    n = 0;
    s_axi_araddr  = addr;
    s_axi_arvalid = 1'b1;
    while (!s_axi_arready && n < 20) begin
      tick();
      n++;
    end
    check_eq("arready", 32'(s_axi_arready), 32'h1);
    tick();
    s_axi_arvalid = 1'b0;
    check_eq("rvalid_n1", 32'(s_axi_rvalid), 32'h1);
    check_eq("rresp", 32'(s_axi_rresp), 32'h0);
    data = s_axi_rdata;
    s_axi_rready = 1'b1;
    tick();
    s_axi_rready = 1'b0;
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [7:0] data, input logic [3:0] strb,
                           input bit aw_first, output logic [1:0] resp);
    int n;
    n = 0;
    while (!(s_axi_awready && s_axi_wready) && n < 20) begin
      tick();
      n++;
    end
    s_axi_awaddr  = addr;
    s_axi_awvalid = 1'b1;
    if (!aw_first) begin
      s_axi_wdata  = {24'h0, data};
      s_axi_wstrb  = strb;
      s_axi_wvalid = 1'b1;
    end
    tick();
    s_axi_awvalid = 1'b0;
    if (aw_first) begin
      s_axi_wdata  = {24'h0, data};
      s_axi_wstrb  = strb;
      s_axi_wvalid = 1'b1;
      tick();
    end
    s_axi_wvalid = 1'b0;
    n = 0;
    while (!s_axi_bvalid && n < 20) begin
      tick();
      n++;
    end
    check_eq("bvalid", 32'(s_axi_bvalid), 32'h1);
    resp = s_axi_bresp;
    s_axi_bready = 1'b1;
    tick();
    s_axi_bready = 1'b0;
  endtask

  task automatic rx_byte(input logic [7:0] data, input logic frame, input logic par);
    rx_in_data  = data;
    rx_in_frame = frame;
    rx_in_par   = par;
    rx_in_vld   = 1'b1;
    tick();
    rx_in_vld   = 1'b0;
    rx_in_frame = 1'b0;
    rx_in_par   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic [1:0]  resp;
    int          pulses;

    rstn = 1'b0;
    s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
    s_axi_wvalid = 1'b0; s_axi_bready = 1'b0; s_axi_araddr = '0; s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b0; rx_in_data = '0; rx_in_vld = 1'b0; rx_in_frame = 1'b0;
    rx_in_par = 1'b0; tx_out_rdy = 1'b0;
    repeat (3) tick();

    check_eq("rst_awready", 32'(s_axi_awready), 32'h0);
    check_eq("rst_wready", 32'(s_axi_wready), 32'h0);
    check_eq("rst_arready", 32'(s_axi_arready), 32'h0);
    check_eq("rst_bvalid", 32'(s_axi_bvalid), 32'h0);
    check_eq("rst_rvalid", 32'(s_axi_rvalid), 32'h0);
    check_eq("rst_rdata", s_axi_rdata, 32'h0);
    check_eq("rst_txvld", 32'(tx_out_vld), 32'h0);
    check_eq("rst_intr", 32'(interrupt), 32'h0);
    rstn = 1'b1;
    tick();

    axi_read(4'h8, rd);
    check_eq("stat_reset", rd, 32'h04);

    // TX path: AW one cycle ahead of W
    axi_write(4'h4, 8'h41, 4'h1, 1'b1, resp);
    check_eq("tx41_bresp", 32'(resp), 32'h0);
    axi_write(4'h4, 8'h42, 4'h1, 1'b1, resp);
    check_eq("tx42_bresp", 32'(resp), 32'h0);
    check_eq("tx_vld_held", 32'(tx_out_vld), 32'h1);
    axi_read(4'h8, rd);
    check_eq("stat_tx2", rd, 32'h00);
    tx_out_rdy = 1'b1;
    check_eq("tx_head0", 32'(tx_out_data), 32'h41);
    tick();
    check_eq("tx_head1", 32'(tx_out_data), 32'h42);
    check_eq("tx_vld1", 32'(tx_out_vld), 32'h1);
    tick();
    check_eq("tx_drained", 32'(tx_out_vld), 32'h0);
    tx_out_rdy = 1'b0;
    axi_read(4'h8, rd);
    check_eq("stat_tx_empty", rd, 32'h04);

    // RX path: 17 bytes into a 16-entry FIFO
    for (int i = 0; i < 17; i++) begin
      rx_in_data = 8'h30 + 8'(i);
      rx_in_vld  = 1'b1;
      tick();
    end
    rx_in_vld = 1'b0;
    axi_read(4'h8, rd);
    check_eq("stat_rx_ovr", rd, 32'h27);
    for (int i = 0; i < 16; i++) begin
      axi_read(4'h0, rd);
      check_eq("rx_byte", rd, 32'h30 + 32'(i));
    end
    axi_read(4'h8, rd);
    check_eq("stat_rx_cleared", rd, 32'h04);
    axi_read(4'h0, rd);
    check_eq("rx_empty_read", rd, 32'h00);
    axi_read(4'h4, rd);
    check_eq("read_tx_reg", rd, 32'h00);

    // TX full: 16 accepted, 17th refused
    for (int i = 0; i < 17; i++) begin
      axi_write(4'h4, 8'h60 + 8'(i), 4'h1, 1'b0, resp);
      check_eq("txfill_bresp", 32'(resp), (i == 16) ? 32'h2 : 32'h0);
    end
    axi_read(4'h8, rd);
    check_eq("stat_tx_full", rd, 32'h08);
    check_eq("tx_full_head", 32'(tx_out_data), 32'h60);
    axi_write(4'hC, 8'h01, 4'h1, 1'b0, resp);
    check_eq("flush_bresp", 32'(resp), 32'h0);
    check_eq("flush_txvld", 32'(tx_out_vld), 32'h0);
    axi_read(4'h8, rd);
    check_eq("stat_flushed", rd, 32'h04);
    axi_write(4'h0, 8'hAA, 4'h1, 1'b1, resp);
    check_eq("bad_addr_bresp", 32'(resp), 32'h2);
    axi_write(4'h4, 8'hAA, 4'h0, 1'b0, resp);
    check_eq("nostrb_bresp", 32'(resp), 32'h0);
    check_eq("nostrb_nopush", 32'(tx_out_vld), 32'h0);

    // Interrupt on RX arrival with a framing error
    axi_write(4'hC, 8'h10, 4'h1, 1'b0, resp);
    check_eq("ctrl_bresp", 32'(resp), 32'h0);
    axi_read(4'h8, rd);
    check_eq("stat_intr_en", rd, 32'h14);
    rx_byte(8'h55, 1'b1, 1'b0);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (interrupt) pulses++;
      tick();
    end
    check_eq("intr_pulses", 32'(pulses), 32'h1);
    axi_read(4'h8, rd);
    check_eq("stat_frame", rd, 32'h55);
    axi_read(4'h0, rd);
    check_eq("rx_55", rd, 32'h55);
    axi_read(4'h0, rd);
    check_eq("rx_after_55", rd, 32'h00);
    axi_read(4'h8, rd);
    check_eq("stat_frame_clr", rd, 32'h14);
    rx_byte(8'h66, 1'b0, 1'b1);
    axi_read(4'h8, rd);
    check_eq("stat_parity", rd, 32'h95);
    axi_read(4'h0, rd);
    check_eq("rx_66", rd, 32'h66);

    // Reset while a read response is pending
    rx_byte(8'h77, 1'b0, 1'b0);
    axi_write(4'h4, 8'h99, 4'h1, 1'b0, resp);
    s_axi_araddr  = 4'h8;
    s_axi_arvalid = 1'b1;
    tick();
    s_axi_arvalid = 1'b0;
    check_eq("pend_rvalid", 32'(s_axi_rvalid), 32'h1);
    check_eq("pend_rdata", s_axi_rdata, 32'h11);
    tick();
    check_eq("hold_rvalid", 32'(s_axi_rvalid), 32'h1);
    check_eq("hold_rdata", s_axi_rdata, 32'h11);
    rstn = 1'b0;
    tick();
    check_eq("rst_mid_rvalid", 32'(s_axi_rvalid), 32'h0);
    check_eq("rst_mid_txvld", 32'(tx_out_vld), 32'h0);
    rstn = 1'b1;
    tick();
    axi_read(4'h8, rd);
    check_eq("stat_after_rst", rd, 32'h04);
    axi_read(4'h0, rd);
    check_eq("rx_after_rst", rd, 32'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
